mimosa_dbg_frame_tx: RTL and testbench
======================================

Name: mimosa_dbg_frame_tx

Overview:
Serial transmitter that reads the model's internal state (dbg_energy, dbg_stress, dbg_pleasure) and ships it off-chip as a fixed 5-byte UART frame on one pin. It is the read-back counterpart to the simulation wrapper that drives stimulus into tt_um_moody_mimosa. It sits beside the model and is fed directly from its dbg_* outputs, with tx routed to a uio pin. Frames start on a trigger pulse or periodically.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); min 2
AUTO_PERIOD, 0, clk cycles between automatic frames; 0 = auto mode off, trigger only
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  enable; low blocks new frames
trigger  input  1  request one frame (level sampled each cycle)
dbg_energy  input  7  model energy state
dbg_stress  input  7  model stress state
dbg_pleasure  input  7  model pleasure state
tx  output  1  UART line, idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst_n low): tx=1, busy=0, frame_done=0, pending=0, auto counter=0, FSM=IDLE. Reset mid-frame aborts the frame and tx returns high immediately. No partial frame resumes.
- Frame: 5 bytes back to back, no inter-byte gap, in this order:
  - SYNC_BYTE
  - {1'b0, E}
  - {1'b0, S}
  - {1'b0, P}
  - CHK = (E+S+P) mod 256, with each field zero-extended to 8 bits
- Byte format: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles. A frame lasts 50*CLKS_PER_BIT cycles.
- Start request: asserted when (trigger | auto_fire | pending) & ena, sampled at edge k while IDLE.
  - At edge k: E/S/P are snapshotted and CHK is computed from the snapshot.
  - From edge k+1: busy=1 and tx=0 (start bit of byte 0).
  - The frame always carries the snapshot; dbg changes during the frame are ignored.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on start request.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START (next byte) if byte_idx<4; otherwise -> IDLE.
  - On STOP -> IDLE: frame_done=1 for one cycle, and busy=0 in that same cycle.
- Counters: bit timer counts 0..CLKS_PER_BIT-1, bit index 0..7, byte index 0..4. All wrap to 0 on state change.
- trigger while busy: sets pending (a single flag, not a counter). The pending frame is treated as a start request in the first IDLE cycle after frame_done, so tx goes low one cycle after the frame_done cycle. Additional triggers while pending=1 are dropped.
- Auto mode (AUTO_PERIOD>0):
  - A free-running counter runs only while ena=1 and clears when ena=0.
  - It fires auto_fire for one cycle at count AUTO_PERIOD-1, then wraps.
  - If the counter fires while busy, it sets pending.
- ena=0: no new frame starts, and pending is held (not cleared). A frame already in progress completes normally.
- Simultaneous trigger and auto_fire in the same cycle produce one frame.
- trigger held high continuously produces back-to-back frames, with one idle cycle between them.

Decomposition:
- Shared package mimosa_dbg_pkg holds:
  - state enum (IDLE/START/DATA/STOP)
  - FRAME_BYTES=5
  - DBG_W=7
  - default SYNC_BYTE
- One natural sub-module, mimosa_baud_tick. It is the bit-period counter with a clear input, a tick output, and parameter CLKS_PER_BIT. It is reused by a future receiver.
- Byte selection mux, checksum and FSM stay in the top module.

Test Plan:
1. CLKS_PER_BIT=4, AUTO_PERIOD=0, E=0x12, S=0x05, P=0x7F, one-cycle trigger -> decoded bytes A5 12 05 7F 96. tx is low at edge k+1, busy is high for 200 cycles, and frame_done pulses once at cycle 200.
2. E=S=P=0x7F -> checksum wraps: bytes A5 7F 7F 7F 7D. With E=S=P=0 -> A5 00 00 00 00.
3. Snapshot: trigger with E=0x01, then change E to 0x55 during byte 0 -> frame carries 0x01. The second trigger is issued mid-frame, so a second frame (E=0x55) starts one idle cycle after frame_done. A third trigger in the same busy window is dropped (only 2 frames total).
4. Assert rst_n low during byte 2 -> tx=1, busy=0 with no clock edge needed. After release, the line stays idle until the next trigger, and the next frame is complete and correct.
5. AUTO_PERIOD=300, CLKS_PER_BIT=4 -> frames start every 300 cycles. Holding ena=0 for 1000 cycles produces no frames. Dropping ena mid-frame lets that frame complete with all 5 bytes.
6. trigger and auto_fire coincide in the same cycle -> exactly one frame and pending stays 0.

Source files
------------

// File: rtl/mimosa_dbg_pkg.sv
// Shared types and constants for the mimosa debug frame transmitter.
package mimosa_dbg_pkg;

    localparam int unsigned FRAME_BYTES = 5;
    localparam int unsigned DBG_W       = 7;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Zero-extend each field and keep the low 8 bits of the sum.
    function automatic logic [7:0] frame_checksum(input logic [DBG_W-1:0] e,
                                                  input logic [DBG_W-1:0] s,
                                                  input logic [DBG_W-1:0] p);
        logic [7:0] sum;
        sum = {1'b0, e} + {1'b0, s} + {1'b0, p};
        return sum;
    endfunction

endpackage

// File: rtl/mimosa_dbg_frame_tx_if.sv
// Control, model-state and serial-line signals of the debug frame transmitter.
interface mimosa_dbg_frame_tx_if;
    import mimosa_dbg_pkg::*;

    logic             ena;
    logic             trigger;
    logic [DBG_W-1:0] dbg_energy;
    logic [DBG_W-1:0] dbg_stress;
    logic [DBG_W-1:0] dbg_pleasure;
    logic             tx;
    logic             busy;
    logic             frame_done;

    modport master (
        output ena, trigger, dbg_energy, dbg_stress, dbg_pleasure,
        input  tx, busy, frame_done
    );

    modport slave (
        input  ena, trigger, dbg_energy, dbg_stress, dbg_pleasure,
        output tx, busy, frame_done
    );

endinterface

// File: rtl/mimosa_baud_tick.sv
// Bit-period counter: tick marks the last cycle of each CLKS_PER_BIT-cycle bit.
module mimosa_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign tick = !clear && (cnt_q == LAST);

    // Count within the bit period; clear holds the count at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mimosa_dbg_frame_tx.sv
// Ships a snapshot of the model's energy/stress/pleasure state as a 5-byte 8N1 frame.
module mimosa_dbg_frame_tx
    import mimosa_dbg_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned AUTO_PERIOD  = 0,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic clk,
    input  logic rst_n,
    mimosa_dbg_frame_tx_if.slave bus
);

    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

    tx_state_e        state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [DBG_W-1:0] e_q, s_q, p_q;
    logic [7:0]       chk_q;
    logic             pending_q, pending_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             tick;
    logic             auto_fire;
    logic             start_req;
    logic [7:0]       cur_byte;

    mimosa_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q == StIdle),
        .tick (tick)
    );

    if (AUTO_PERIOD > 0) begin : g_auto
        localparam int unsigned AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
        localparam logic [AW-1:0] ALAST = AW'(AUTO_PERIOD - 1);

        logic [AW-1:0] auto_cnt_q;

        assign auto_fire = bus.ena && (auto_cnt_q == ALAST);

        // Free-running period counter, cleared whenever the block is disabled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                auto_cnt_q <= '0;
            end else if (!bus.ena || auto_fire) begin
                auto_cnt_q <= '0;
            end else begin
                auto_cnt_q <= auto_cnt_q + 1'b1;
            end
        end
    end else begin : g_no_auto
        assign auto_fire = 1'b0;
    end

    assign start_req = (state_q == StIdle) && bus.ena &&
                       (bus.trigger || auto_fire || pending_q);

    assign bus.tx         = tx_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.frame_done = done_q;

    // Byte currently on the wire, chosen from the frozen snapshot.
    always_comb begin
        cur_byte = chk_q;
        case (byte_idx_d)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = {1'b0, e_q};
            3'd2:    cur_byte = {1'b0, s_q};
            3'd3:    cur_byte = {1'b0, p_q};
            default: cur_byte = chk_q;
        endcase
    end

    // Next state, counters, pending flag and registered line level.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        done_d     = 1'b0;
        pending_d  = pending_q;

        if (start_req) begin
            pending_d = 1'b0;
        end else if ((state_q != StIdle) && (bus.trigger || auto_fire)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    state_d    = StStart;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = StStop;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d    = StIdle;
                        byte_idx_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = StStart;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the next state so tx is glitch-free from a flop.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
    end

    // FSM, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            pending_q  <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            pending_q  <= pending_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    // Snapshot the model state and its checksum when a frame is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= '0;
            s_q   <= '0;
            p_q   <= '0;
            chk_q <= '0;
        end else if (start_req) begin
            e_q   <= bus.dbg_energy;
            s_q   <= bus.dbg_stress;
            p_q   <= bus.dbg_pleasure;
            chk_q <= frame_checksum(bus.dbg_energy, bus.dbg_stress, bus.dbg_pleasure);
        end
    end

endmodule

// File: tb/tb_mimosa_dbg_frame_tx.sv
// Directed bench: decodes frames from recorded tx traces against hand-computed bytes.
module tb_mimosa_dbg_frame_tx;

    localparam int CPB = 4;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_pass;

    logic tx_tr   [0:1299];
    logic busy_tr [0:1299];
    logic done_tr [0:1299];

    mimosa_dbg_frame_tx_if bus_a ();
    mimosa_dbg_frame_tx_if bus_b ();

    mimosa_dbg_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .AUTO_PERIOD (0),
        .SYNC_BYTE   (8'hA5)
    ) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a.slave)
    );

    mimosa_dbg_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .AUTO_PERIOD (300),
        .SYNC_BYTE   (8'hA5)
    ) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raw 10-bit character {stop, data, start} of byte j of a frame starting at trace index base.
    function automatic logic [9:0] char_at(input int base, input int j);
        logic [9:0] c;
        for (int i = 0; i < 10; i++) begin
            c[i] = tx_tr[base + (j * 10 + i) * CPB + CPB / 2];
        end
        return c;
    endfunction

    // Record n samples of DUT A, one per falling edge, starting with the current one.
    task automatic record_a(input int n);
        for (int i = 0; i < n; i++) begin
            tx_tr[i]   = bus_a.tx;
            busy_tr[i] = bus_a.busy;
            done_tr[i] = bus_a.frame_done;
            @(negedge clk);
        end
    endtask

    task automatic pulse_trigger_a();
        bus_a.trigger = 1'b1;
        @(negedge clk);
        bus_a.trigger = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus_a.tx, bus_a.busy, bus_a.frame_done} !== 3'b100) begin
            $display("FAIL reset_a: got tx/busy/done=%b want 100",
                     {bus_a.tx, bus_a.busy, bus_a.frame_done});
        end else n_pass++;
        n_checks++;
        if ({bus_b.tx, bus_b.busy, bus_b.frame_done} !== 3'b100) begin
            $display("FAIL reset_b: got tx/busy/done=%b want 100",
                     {bus_b.tx, bus_b.busy, bus_b.frame_done});
        end else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [7:0] exp [5];
        int busy_cnt;
        int done_cnt;
        exp = '{8'hA5, 8'h12, 8'h05, 8'h7F, 8'h96};
        bus_a.dbg_energy   = 7'h12;
        bus_a.dbg_stress   = 7'h05;
        bus_a.dbg_pleasure = 7'h7F;
        pulse_trigger_a();
        record_a(215);
        n_checks++;
        if (tx_tr[0] !== 1'b0 || busy_tr[0] !== 1'b1) begin
            $display("FAIL single_start: got tx=%b busy=%b want tx=0 busy=1", tx_tr[0], busy_tr[0]);
        end else n_pass++;
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (char_at(0, j) !== {1'b1, exp[j], 1'b0}) begin
                $display("FAIL single_byte%0d: got %b want %b", j, char_at(0, j), {1'b1, exp[j], 1'b0});
            end else n_pass++;
        end
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 215; i++) begin
            busy_cnt += int'(busy_tr[i]);
            done_cnt += int'(done_tr[i]);
        end
        n_checks++;
        if (busy_cnt !== 200) begin
            $display("FAIL single_busy_len: got %0d want 200", busy_cnt);
        end else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || done_tr[200] !== 1'b1 || busy_tr[200] !== 1'b0) begin
            $display("FAIL single_done: got count=%0d done@200=%b busy@200=%b want 1,1,0",
                     done_cnt, done_tr[200], busy_tr[200]);
        end else n_pass++;
    endtask

    task automatic test_checksum();
        logic [7:0] exp [5];
        exp = '{8'hA5, 8'h7F, 8'h7F, 8'h7F, 8'h7D};
        bus_a.dbg_energy   = 7'h7F;
        bus_a.dbg_stress   = 7'h7F;
        bus_a.dbg_pleasure = 7'h7F;
        pulse_trigger_a();
        record_a(205);
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (char_at(0, j) !== {1'b1, exp[j], 1'b0}) begin
                $display("FAIL wrap_byte%0d: got %b want %b", j, char_at(0, j), {1'b1, exp[j], 1'b0});
            end else n_pass++;
        end
        exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        bus_a.dbg_energy   = 7'h00;
        bus_a.dbg_stress   = 7'h00;
        bus_a.dbg_pleasure = 7'h00;
        pulse_trigger_a();
        record_a(205);
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (char_at(0, j) !== {1'b1, exp[j], 1'b0}) begin
                $display("FAIL zero_byte%0d: got %b want %b", j, char_at(0, j), {1'b1, exp[j], 1'b0});
            end else n_pass++;
        end
    endtask

    task automatic test_snapshot_pending();
        logic [7:0] exp1 [5];
        logic [7:0] exp2 [5];
        int done_cnt;
        int late_busy;
        exp1 = '{8'hA5, 8'h01, 8'h10, 8'h20, 8'h31};
        exp2 = '{8'hA5, 8'h55, 8'h10, 8'h20, 8'h85};
        bus_a.dbg_energy   = 7'h01;
        bus_a.dbg_stress   = 7'h10;
        bus_a.dbg_pleasure = 7'h20;
        pulse_trigger_a();
        for (int i = 0; i < 440; i++) begin
            tx_tr[i]   = bus_a.tx;
            busy_tr[i] = bus_a.busy;
            done_tr[i] = bus_a.frame_done;
            if (i == 5)  bus_a.dbg_energy = 7'h55;
            if (i == 20) bus_a.trigger = 1'b1;
            if (i == 21) bus_a.trigger = 1'b0;
            if (i == 60) bus_a.trigger = 1'b1;
            if (i == 61) bus_a.trigger = 1'b0;
            @(negedge clk);
        end
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (char_at(0, j) !== {1'b1, exp1[j], 1'b0}) begin
                $display("FAIL snap1_byte%0d: got %b want %b", j, char_at(0, j), {1'b1, exp1[j], 1'b0});
            end else n_pass++;
        end
        n_checks++;
        if (done_tr[200] !== 1'b1 || tx_tr[200] !== 1'b1 || tx_tr[201] !== 1'b0) begin
            $display("FAIL pending_gap: got done@200=%b tx@200=%b tx@201=%b want 1,1,0",
                     done_tr[200], tx_tr[200], tx_tr[201]);
        end else n_pass++;
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (char_at(201, j) !== {1'b1, exp2[j], 1'b0}) begin
                $display("FAIL snap2_byte%0d: got %b want %b", j, char_at(201, j), {1'b1, exp2[j], 1'b0});
            end else n_pass++;
        end
        done_cnt = 0;
        late_busy = 0;
        for (int i = 0; i < 440; i++) done_cnt += int'(done_tr[i]);
        for (int i = 402; i < 440; i++) late_busy += int'(busy_tr[i]);
        n_checks++;
        if (done_cnt !== 2 || done_tr[401] !== 1'b1 || late_busy !== 0) begin
            $display("FAIL drop_third: got done_cnt=%0d done@401=%b late_busy=%0d want 2,1,0",
                     done_cnt, done_tr[401], late_busy);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp [5];
        int low_cnt;
        exp = '{8'hA5, 8'h2A, 8'h33, 8'h44, 8'hA1};
        bus_a.dbg_energy   = 7'h11;
        bus_a.dbg_stress   = 7'h22;
        bus_a.dbg_pleasure = 7'h33;
        pulse_trigger_a();
        repeat (95) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_a.tx !== 1'b1 || bus_a.busy !== 1'b0) begin
            $display("FAIL async_reset: got tx=%b busy=%b want tx=1 busy=0", bus_a.tx, bus_a.busy);
        end else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        record_a(60);
        low_cnt = 0;
        for (int i = 0; i < 60; i++) low_cnt += int'(!tx_tr[i] || busy_tr[i]);
        n_checks++;
        if (low_cnt !== 0) begin
            $display("FAIL post_reset_idle: got %0d active cycles want 0", low_cnt);
        end else n_pass++;
        bus_a.dbg_energy   = 7'h2A;
        bus_a.dbg_stress   = 7'h33;
        bus_a.dbg_pleasure = 7'h44;
        pulse_trigger_a();
        record_a(205);
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (char_at(0, j) !== {1'b1, exp[j], 1'b0}) begin
                $display("FAIL post_reset_byte%0d: got %b want %b", j, char_at(0, j), {1'b1, exp[j], 1'b0});
            end else n_pass++;
        end
    endtask

    task automatic test_auto_mode();
        logic [7:0] exp [5];
        int busy_cnt;
        int rises;
        int rise1;
        int rise2;
        int late_busy;
        exp = '{8'hA5, 8'h33, 8'h44, 8'h01, 8'h78};
        bus_b.dbg_energy   = 7'h33;
        bus_b.dbg_stress   = 7'h44;
        bus_b.dbg_pleasure = 7'h01;
        busy_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            busy_cnt += int'(bus_b.busy);
            if (i == 500) bus_b.trigger = 1'b1;
            if (i == 501) bus_b.trigger = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (busy_cnt !== 0) begin
            $display("FAIL ena_low_idle: got %0d busy cycles want 0", busy_cnt);
        end else n_pass++;
        bus_b.ena = 1'b1;
        busy_tr[0] = 1'b0;
        for (int i = 1; i <= 1150; i++) begin
            @(negedge clk);
            tx_tr[i]   = bus_b.tx;
            busy_tr[i] = bus_b.busy;
            done_tr[i] = bus_b.frame_done;
            if (i == 960) bus_b.ena = 1'b0;
        end
        rises = 0;
        rise1 = -1;
        rise2 = -1;
        for (int i = 1; i <= 1150; i++) begin
            if (busy_tr[i] && !busy_tr[i-1]) begin
                if (rises == 0) rise1 = i;
                if (rises == 1) rise2 = i;
                rises++;
            end
        end
        n_checks++;
        if (rise1 !== 300 || rise2 !== 600 || rises !== 3) begin
            $display("FAIL auto_period: got rises=%0d first=%0d second=%0d want 3,300,600",
                     rises, rise1, rise2);
        end else n_pass++;
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (char_at(900, j) !== {1'b1, exp[j], 1'b0}) begin
                $display("FAIL ena_drop_byte%0d: got %b want %b", j, char_at(900, j), {1'b1, exp[j], 1'b0});
            end else n_pass++;
        end
        late_busy = 0;
        for (int i = 1101; i <= 1150; i++) late_busy += int'(busy_tr[i]);
        n_checks++;
        if (done_tr[1100] !== 1'b1 || late_busy !== 0) begin
            $display("FAIL ena_drop_done: got done@1100=%b late_busy=%0d want 1,0",
                     done_tr[1100], late_busy);
        end else n_pass++;
    endtask

    task automatic test_coincident();
        int idle_busy;
        int done_cnt;
        bus_b.ena = 1'b1;
        busy_tr[0] = 1'b0;
        for (int i = 1; i <= 620; i++) begin
            @(negedge clk);
            busy_tr[i] = bus_b.busy;
            done_tr[i] = bus_b.frame_done;
            if (i == 299) bus_b.trigger = 1'b1;
            if (i == 300) bus_b.trigger = 1'b0;
        end
        bus_b.ena = 1'b0;
        n_checks++;
        if (busy_tr[299] !== 1'b0 || busy_tr[300] !== 1'b1) begin
            $display("FAIL coinc_start: got busy@299=%b busy@300=%b want 0,1", busy_tr[299], busy_tr[300]);
        end else n_pass++;
        idle_busy = 0;
        done_cnt = 0;
        for (int i = 501; i < 600; i++) idle_busy += int'(busy_tr[i]);
        for (int i = 1; i < 600; i++) done_cnt += int'(done_tr[i]);
        n_checks++;
        if (idle_busy !== 0 || done_cnt !== 1 || done_tr[500] !== 1'b1 || busy_tr[600] !== 1'b1) begin
            $display("FAIL coinc_single: got idle_busy=%0d done_cnt=%0d done@500=%b busy@600=%b want 0,1,1,1",
                     idle_busy, done_cnt, done_tr[500], busy_tr[600]);
        end else n_pass++;
        repeat (220) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus_a.ena = 1'b1;
        bus_a.trigger = 1'b0;
        bus_a.dbg_energy = '0;
        bus_a.dbg_stress = '0;
        bus_a.dbg_pleasure = '0;
        bus_b.ena = 1'b0;
        bus_b.trigger = 1'b0;
        bus_b.dbg_energy = '0;
        bus_b.dbg_stress = '0;
        bus_b.dbg_pleasure = '0;
        #22;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_single_frame();
        test_checksum();
        test_snapshot_pending();
        test_reset_mid_frame();
        test_auto_mode();
        test_coincident();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
